// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, PRESCALE-times oversampling, optional parity.
// Define UART_RX_MAJORITY_VOTE_EN for a 2-of-3 vote around each bit centre.
module uart_rx #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 8,
    parameter logic        STOP     = 1'b1,
    parameter logic        START    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX_IN,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [WIDTH-1:0] P_DATA,
    output logic             DATA_VALID,
    output logic             PAR_ERR,
    output logic             STP_ERR,
    output logic             Busy
);

    localparam int unsigned ECW = $clog2(PRESCALE);
    localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int unsigned SAMPLE_TICK = PRESCALE / 2 + 1;
`else
    localparam int unsigned SAMPLE_TICK = PRESCALE / 2;
`endif
    localparam logic [ECW-1:0] TICK_SAMPLE = ECW'(SAMPLE_TICK);
    localparam logic [ECW-1:0] TICK_LAST   = ECW'(PRESCALE - 1);
    localparam logic [BCW-1:0] BIT_LAST    = BCW'(WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e           state;
    logic [ECW-1:0]   edge_cnt;
    logic [BCW-1:0]   bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_en_q;
    logic             par_typ_q;
    logic             par_bad;
    logic             rx_meta;
    logic             rx_s;
    logic             sample;
    logic             at_sample;
    logic             at_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // hist[1] = rx_s two ticks ago, hist[0] = previous tick; vote completes at TICK_SAMPLE.
    logic [1:0] hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    assign at_sample = (edge_cnt == TICK_SAMPLE);
    assign at_wrap   = (edge_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            if (state != StIdle) begin
                edge_cnt <= at_wrap ? '0 : edge_cnt + 1'b1;
            end
            unique case (state)
                StIdle: begin
                    // The detection cycle is tick 0 of the start bit.
                    if (rx_s == START) begin
                        state     <= StStart;
                        edge_cnt  <= ECW'(1);
                        bit_cnt   <= '0;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_bad   <= 1'b0;
                        Busy      <= 1'b1;
                    end
                end
                StStart: begin
                    if (at_sample && sample != START) begin
                        state    <= StIdle;
                        edge_cnt <= '0;
                        Busy     <= 1'b0;
                    end else if (at_wrap) begin
                        state <= StData;
                    end
                end
                StData: begin
                    if (at_sample) begin
                        shreg <= {sample, shreg[WIDTH-1:1]};
                    end
                    if (at_wrap) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? StParity : StStop;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (at_sample) begin
                        par_bad <= (sample != ((^shreg) ^ par_typ_q));
                    end
                    if (at_wrap) begin
                        state <= StStop;
                    end
                end
                StStop: begin
                    // Leave mid-stop-bit so a following start edge is not missed.
                    if (at_sample) begin
                        PAR_ERR  <= par_bad;
                        STP_ERR  <= (sample != STOP);
                        if (!par_bad && sample == STOP) begin
                            P_DATA     <= shreg;
                            DATA_VALID <= 1'b1;
                        end
                        state    <= StIdle;
                        edge_cnt <= '0;
                        Busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (PRESCALE=8, WIDTH=8).
module tb_uart_rx;

    localparam int unsigned PRESCALE = 8;
    localparam int unsigned WIDTH    = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int unsigned SAMPLE = PRESCALE / 2 + 1;
`else
    localparam int unsigned SAMPLE = PRESCALE / 2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             RX_IN = 1'b1;
    logic             PAR_EN = 1'b0;
    logic             PAR_TYP = 1'b0;
    logic [WIDTH-1:0] P_DATA;
    logic             DATA_VALID;
    logic             PAR_ERR;
    logic             STP_ERR;
    logic             Busy;

    uart_rx #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE),
        .STOP     (1'b1),
        .START    (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts high cycles of each output on the falling edge.
    int         dv_cnt = 0;
    int         pe_cnt = 0;
    int         se_cnt = 0;
    int         busy_cnt = 0;
    logic [7:0] dv_q[$];

    always @(negedge clk) begin
        if (DATA_VALID) begin
            dv_cnt <= dv_cnt + 1;
            dv_q.push_back(P_DATA);
        end
        if (PAR_ERR) pe_cnt <= pe_cnt + 1;
        if (STP_ERR) se_cnt <= se_cnt + 1;
        if (Busy) busy_cnt <= busy_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;
    int dv0, pe0, se0, bz0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        dv0 = dv_cnt;
        pe0 = pe_cnt;
        se0 = se_cnt;
        bz0 = busy_cnt;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        RX_IN = b;
        if (glitch) begin
            tick(PRESCALE / 2);
            RX_IN = ~b;
            tick(1);
            RX_IN = b;
            tick(PRESCALE / 2 - 1);
        end else begin
            tick(PRESCALE);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input bit with_par, input logic par_bit,
                              input logic stop_bit, input bit flip, input int glitch);
        send_bit(1'b0, 1'b0);
        if (flip) begin
            PAR_EN  = ~PAR_EN;
            PAR_TYP = ~PAR_TYP;
        end
        for (int i = 0; i < 8; i++) send_bit(data[i], (glitch == i));
        if (with_par) send_bit(par_bit, 1'b0);
        send_bit(stop_bit, 1'b0);
        RX_IN = 1'b1;
    endtask

    initial begin
        tick(3);
        check("rst_p_data", P_DATA, 0);
        check("rst_dv", DATA_VALID, 0);
        check("rst_pe", PAR_ERR, 0);
        check("rst_se", STP_ERR, 0);
        check("rst_busy", Busy, 0);
        rst = 1'b0;
        tick(4);

        // Good frame with even parity.
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        snap();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        tick(2 * PRESCALE);
        check("a5_data", P_DATA, 8'hA5);
        check("a5_dv", dv_cnt - dv0, 1);
        check("a5_pe", pe_cnt - pe0, 0);
        check("a5_se", se_cnt - se0, 0);
        check("a5_busy_cycles", busy_cnt - bz0, 10 * PRESCALE + SAMPLE);
        check("a5_busy_end", Busy, 0);

        // Wrong parity bit.
        snap();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        tick(2 * PRESCALE);
        check("3c_pe", pe_cnt - pe0, 1);
        check("3c_dv", dv_cnt - dv0, 0);
        check("3c_se", se_cnt - se0, 0);
        check("3c_hold", P_DATA, 8'hA5);

        // Stop bit low, no parity.
        PAR_EN = 1'b0;
        snap();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        tick(2 * PRESCALE);
        check("81_se", se_cnt - se0, 1);
        check("81_dv", dv_cnt - dv0, 0);
        check("81_pe", pe_cnt - pe0, 0);

        // False start: two low clocks.
        snap();
        RX_IN = 1'b0;
        tick(2);
        RX_IN = 1'b1;
        tick(2 * PRESCALE);
        check("fs_strobes", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        check("fs_busy_cycles", busy_cnt - bz0, SAMPLE);
        check("fs_busy_end", Busy, 0);
        snap();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        tick(2 * PRESCALE);
        check("5a_dv", dv_cnt - dv0, 1);
        check("5a_data", P_DATA, 8'h5A);

        // Odd parity; PAR_EN/PAR_TYP flip after the start bit must be ignored.
        PAR_EN = 1'b1; PAR_TYP = 1'b1;
        snap();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        tick(2 * PRESCALE);
        check("07_dv", dv_cnt - dv0, 1);
        check("07_pe", pe_cnt - pe0, 0);
        check("07_se", se_cnt - se0, 0);
        check("07_data", P_DATA, 8'h07);

        // Back-to-back frames without idle gap (PAR_EN is now 0).
        snap();
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        tick(2 * PRESCALE);
        check("b2b_dv", dv_cnt - dv0, 2);
        check("b2b_first", dv_q[dv_q.size() - 2], 8'h00);
        check("b2b_second", dv_q[dv_q.size() - 1], 8'hFF);
        check("b2b_se", se_cnt - se0, 0);

        // Line stuck low.
        snap();
        RX_IN = 1'b0;
        tick(25 * PRESCALE);
        check("low_se_repeat", (se_cnt - se0) >= 2, 1);
        check("low_dv", dv_cnt - dv0, 0);
        check("low_pe", pe_cnt - pe0, 0);
        RX_IN = 1'b1;
        tick(12 * PRESCALE);
        check("low_busy_end", Busy, 0);

        // Reset during bit 4 of 0x77.
        snap();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h77 >> i), 1'b0);
        RX_IN = 1'b1;
        tick(PRESCALE / 2);
        rst = 1'b1;
        tick(2);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_data", P_DATA, 0);
        rst = 1'b0;
        tick(12 * PRESCALE);
        check("mid_rst_no_dv", dv_cnt - dv0, 0);
        check("mid_rst_no_err", (pe_cnt - pe0) + (se_cnt - se0), 0);
        snap();
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        tick(2 * PRESCALE);
        check("12_dv", dv_cnt - dv0, 1);
        check("12_data", P_DATA, 8'h12);

`ifdef UART_RX_MAJORITY_VOTE_EN
        // Single-cycle glitch at the centre of data bit 2.
        snap();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        tick(2 * PRESCALE);
        check("glitch_dv", dv_cnt - dv0, 1);
        check("glitch_data", P_DATA, 8'hC3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
